// File: rtl/des_pkg.sv
// Shared types and constants for the DES/3DES round-sequencing controller.
package des_pkg;

    localparam int DES_ROUNDS  = 16;
    localparam int TDES_PASSES = 3;
    localparam int DES_BLOCK_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PERMUTE,
        ST_KEYGEN,
        ST_ROUND,
        ST_INV_PERMUTE,
        ST_DATA_READY
    } tdes_state_t;

    // EDE: the middle pass of 3DES runs the key schedule in the opposite direction.
    function automatic logic pass_reverse(input logic mode_enc, input logic middle_pass);
        return ~mode_enc ^ middle_pass;
    endfunction

endpackage

// File: rtl/des_round_counter.sv
// Round counter for the DES controller: synchronous clear, count enable,
// terminal-count flag against a programmable rollover value.
module des_round_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count,
    output logic         rollover_flag
);

    assign rollover_flag = (count == rollover_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= rollover_flag ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tdes_round_controller.sv
// DES/3DES round sequencer: IP -> NUM_ROUNDS x (keygen, round) -> FP per pass,
// then holds the result until the consumer accepts it.
//
// state          | meaning
// ---------------+------------------------------------------------
// ST_IDLE        | waiting for a block, in_ready high
// ST_LOAD        | datapath captures the input block
// ST_PERMUTE     | initial permutation, round counter cleared
// ST_KEYGEN      | advance key schedule one round
// ST_ROUND       | execute one Feistel round
// ST_INV_PERMUTE | final permutation, next pass or done
// ST_DATA_READY  | result held, out_valid high until out_ready
module tdes_round_controller
    import des_pkg::*;
#(
    parameter int   NUM_ROUNDS = DES_ROUNDS,
    parameter int   NUM_PASSES = 1,
    localparam int  ROUND_W    = $clog2(NUM_ROUNDS),
    localparam int  PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               encrypt,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               load_en,
    output logic               ip_en,
    output logic               key_enable,
    output logic               des_enable,
    output logic               fp_en,
    output logic               reverse,
    output logic [PASS_W-1:0]  key_sel,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy
);

    if (!(NUM_PASSES == 1 || NUM_PASSES == TDES_PASSES)) begin : g_bad_passes
        $error("tdes_round_controller: NUM_PASSES must be 1 or 3");
    end
    if (NUM_ROUNDS < 2) begin : g_bad_rounds
        $error("tdes_round_controller: NUM_ROUNDS must be at least 2");
    end

    localparam logic [PASS_W-1:0]  LAST_PASS  = PASS_W'(NUM_PASSES - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    tdes_state_t       state, state_nxt;
    logic [PASS_W-1:0] pass_cnt, pass_nxt;
    logic              mode_enc, mode_nxt;
    logic              round_last;
    logic              rnd_clear, rnd_count_en;

    // Clearing at the DATA_READY exit keeps round_idx at 0 throughout IDLE.
    assign rnd_clear    = abort || (state == ST_IDLE) || (state == ST_PERMUTE) ||
                          ((state == ST_DATA_READY) && out_ready);
    assign rnd_count_en = (state == ST_ROUND) && !round_last;

    des_round_counter #(.W(ROUND_W)) u_round_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (rnd_clear),
        .count_en     (rnd_count_en),
        .rollover_val (LAST_ROUND),
        .count        (round_idx),
        .rollover_flag(round_last)
    );

    always_comb begin
        state_nxt = state;
        pass_nxt  = pass_cnt;
        mode_nxt  = mode_enc;
        if (abort) begin
            state_nxt = ST_IDLE;
            pass_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_nxt = ST_LOAD;
                        mode_nxt  = encrypt;
                    end
                end
                ST_LOAD:    state_nxt = ST_PERMUTE;
                ST_PERMUTE: state_nxt = ST_KEYGEN;
                ST_KEYGEN:  state_nxt = ST_ROUND;
                ST_ROUND:   state_nxt = round_last ? ST_INV_PERMUTE : ST_KEYGEN;
                ST_INV_PERMUTE: begin
                    if (pass_cnt == LAST_PASS) begin
                        state_nxt = ST_DATA_READY;
                    end else begin
                        state_nxt = ST_PERMUTE;
                        pass_nxt  = pass_cnt + 1'b1;
                    end
                end
                ST_DATA_READY: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                        pass_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    pass_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pass_cnt   <= '0;
            mode_enc   <= 1'b1;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            load_en    <= 1'b0;
            ip_en      <= 1'b0;
            key_enable <= 1'b0;
            des_enable <= 1'b0;
            fp_en      <= 1'b0;
            busy       <= 1'b0;
            reverse    <= 1'b0;
            key_sel    <= '0;
        end else begin
            state      <= state_nxt;
            pass_cnt   <= pass_nxt;
            mode_enc   <= mode_nxt;
            in_ready   <= (state_nxt == ST_IDLE);
            out_valid  <= (state_nxt == ST_DATA_READY);
            load_en    <= (state_nxt == ST_LOAD);
            ip_en      <= (state_nxt == ST_PERMUTE);
            key_enable <= (state_nxt == ST_KEYGEN);
            des_enable <= (state_nxt == ST_ROUND);
            fp_en      <= (state_nxt == ST_INV_PERMUTE);
            busy       <= (state_nxt != ST_IDLE);
            reverse    <= pass_reverse(mode_nxt,
                                       (NUM_PASSES == TDES_PASSES) && (pass_nxt == PASS_W'(1)));
            key_sel    <= mode_nxt ? pass_nxt : (LAST_PASS - pass_nxt);
        end
    end

endmodule

// File: tb/tb_tdes_round_controller.sv
// Directed bench for tdes_round_controller: one DES and one 3DES instance,
// expected per-block results queued at drive time and compared on out_valid.
module tb_tdes_round_controller;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, encrypt, abort, out_ready, sel_tdes;

    always #5 clk = ~clk;

    logic       d_in_ready, d_out_valid, d_load, d_ip, d_key, d_des, d_fp, d_rev, d_busy;
    logic [0:0] d_ks;
    logic [3:0] d_ridx;
    logic       t_in_ready, t_out_valid, t_load, t_ip, t_key, t_des, t_fp, t_rev, t_busy;
    logic [1:0] t_ks;
    logic [3:0] t_ridx;

    tdes_round_controller #(.NUM_ROUNDS(16), .NUM_PASSES(1)) dut_des (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel_tdes), .in_ready(d_in_ready),
        .encrypt(encrypt), .abort(abort), .out_valid(d_out_valid), .out_ready(out_ready),
        .load_en(d_load), .ip_en(d_ip), .key_enable(d_key), .des_enable(d_des), .fp_en(d_fp),
        .reverse(d_rev), .key_sel(d_ks), .round_idx(d_ridx), .busy(d_busy)
    );

    tdes_round_controller #(.NUM_ROUNDS(16), .NUM_PASSES(3)) dut_tdes (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel_tdes), .in_ready(t_in_ready),
        .encrypt(encrypt), .abort(abort), .out_valid(t_out_valid), .out_ready(out_ready),
        .load_en(t_load), .ip_en(t_ip), .key_enable(t_key), .des_enable(t_des), .fp_en(t_fp),
        .reverse(t_rev), .key_sel(t_ks), .round_idx(t_ridx), .busy(t_busy)
    );

    logic       obs_in_ready, obs_out_valid, obs_load, obs_ip, obs_key, obs_des, obs_fp, obs_rev, obs_busy;
    logic [1:0] obs_ks;
    logic [3:0] obs_ridx;

    always_comb begin
        obs_in_ready  = sel_tdes ? t_in_ready  : d_in_ready;
        obs_out_valid = sel_tdes ? t_out_valid : d_out_valid;
        obs_load      = sel_tdes ? t_load      : d_load;
        obs_ip        = sel_tdes ? t_ip        : d_ip;
        obs_key       = sel_tdes ? t_key       : d_key;
        obs_des       = sel_tdes ? t_des       : d_des;
        obs_fp        = sel_tdes ? t_fp        : d_fp;
        obs_rev       = sel_tdes ? t_rev       : d_rev;
        obs_busy      = sel_tdes ? t_busy      : d_busy;
        obs_ks        = sel_tdes ? t_ks        : {1'b0, d_ks};
        obs_ridx      = sel_tdes ? t_ridx      : d_ridx;
    end

    typedef struct packed {
        logic [7:0] lat;
        logic [1:0] passes;
        logic [2:0] rev;
        logic [5:0] ks;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_chk++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Latency is counted in negedge samples from the one that presents the block (cycle 0).
    task automatic run_block(input logic enc, input logic tdes, input logic [7:0] lat,
                             input logic [2:0] rev, input logic [5:0] ks);
        exp_t       e, got;
        int         cyc, n_key, n_des, n_ip, n_fp, pass, pi, rnd;
        logic       prev_key, done;
        logic [2:0] grev;
        logic [5:0] gks;
        sel_tdes = tdes;
        e.lat = lat; e.passes = tdes ? 2'd3 : 2'd1; e.rev = rev; e.ks = ks;
        @(negedge clk);
        chk("idle_in_ready", obs_in_ready, 1);
        encrypt  = enc;
        in_valid = 1'b1;
        sb.push_back(e);
        cyc = 0; n_key = 0; n_des = 0; n_ip = 0; n_fp = 0; pass = -1; rnd = 0;
        prev_key = 1'b0; done = 1'b0; grev = '0; gks = '0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            if (cyc == 1) begin
                chk("accept_in_ready", obs_in_ready, 0);
                chk("accept_load_en", obs_load, 1);
                chk("accept_busy", obs_busy, 1);
            end
            if (obs_ip) begin
                n_ip++;
                pass++;
                rnd = 0;
                if (pass < 3) begin
                    grev[pass]       = obs_rev;
                    gks[pass*2 +: 2] = obs_ks;
                end
            end
            pi = (pass < 0) ? 0 : ((pass > 2) ? 2 : pass);
            if (obs_key) n_key++;
            if (obs_fp)  n_fp++;
            if (obs_des) begin
                n_des++;
                chk("key_then_round", prev_key, 1);
                chk("round_idx", obs_ridx, rnd);
                chk("reverse_stable", obs_rev, grev[pi]);
                chk("key_sel_stable", obs_ks, gks[pi*2 +: 2]);
                rnd++;
            end
            prev_key = obs_key;
            if (obs_out_valid) done = 1'b1;
        end
        got = sb.pop_front();
        chk("latency", cyc, got.lat);
        chk("key_enable_pulses", n_key, got.passes * 16);
        chk("des_enable_pulses", n_des, got.passes * 16);
        chk("ip_en_pulses", n_ip, got.passes);
        chk("fp_en_pulses", n_fp, got.passes);
        chk("pass_reverse", grev, got.rev);
        chk("pass_key_sel", gks, got.ks);
    endtask

    initial begin
        int   cyc, n_ip;
        logic found, ov_seen;
        rst = 1'b1; in_valid = 1'b0; encrypt = 1'b0; abort = 1'b0; out_ready = 1'b1; sel_tdes = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_des_in_ready", d_in_ready, 1);
        chk("rst_des_strobes", {d_out_valid, d_load, d_ip, d_key, d_des, d_fp}, 0);
        chk("rst_des_busy_rev_ks_idx", {d_busy, d_rev, d_ks, d_ridx}, 0);
        chk("rst_tdes_in_ready", t_in_ready, 1);
        chk("rst_tdes_strobes", {t_out_valid, t_load, t_ip, t_key, t_des, t_fp}, 0);
        chk("rst_tdes_busy_rev_ks_idx", {t_busy, t_rev, t_ks, t_ridx}, 0);
        rst = 1'b0;

        run_block(1'b1, 1'b0, 8'd36, 3'b000, 6'b000000);
        @(negedge clk);
        chk("des_release_out_valid", obs_out_valid, 0);
        chk("des_release_in_ready", obs_in_ready, 1);

        run_block(1'b0, 1'b0, 8'd36, 3'b001, 6'b000000);
        run_block(1'b1, 1'b1, 8'd104, 3'b010, 6'b10_01_00);
        run_block(1'b0, 1'b1, 8'd104, 3'b101, 6'b00_01_10);

        // Backpressure: result held, new blocks ignored.
        out_ready = 1'b0;
        run_block(1'b1, 1'b0, 8'd36, 3'b000, 6'b000000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid_held", obs_out_valid, 1);
            chk("bp_in_ready_low", obs_in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", obs_out_valid, 0);
        chk("bp_release_in_ready", obs_in_ready, 1);

        // abort beats in_valid in IDLE.
        sel_tdes = 1'b0; in_valid = 1'b1; abort = 1'b1; encrypt = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_idle_in_ready", obs_in_ready, 1);
        chk("abort_idle_busy", obs_busy, 0);

        // abort while executing round 7.
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (obs_des && obs_ridx == 4'd7) found = 1'b1;
        end
        chk("abort_reach_round7", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", obs_in_ready, 1);
        chk("abort_busy", obs_busy, 0);
        chk("abort_out_valid", obs_out_valid, 0);
        chk("abort_round_idx", obs_ridx, 0);
        ov_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (obs_out_valid) ov_seen = 1'b1;
        end
        chk("abort_no_result", ov_seen, 0);
        run_block(1'b1, 1'b0, 8'd36, 3'b000, 6'b000000);

        // Reset during pass 2 of a 3DES block.
        sel_tdes = 1'b1; encrypt = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0; cyc = 0; n_ip = 0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (obs_ip) n_ip++;
            if (n_ip == 2 && obs_des && obs_ridx == 4'd3) found = 1'b1;
        end
        chk("rst_reach_pass2", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {obs_out_valid, obs_load, obs_ip, obs_key, obs_des, obs_fp}, 0);
        chk("rst_mid_busy", obs_busy, 0);
        chk("rst_mid_in_ready", obs_in_ready, 1);
        @(negedge clk);
        chk("rst_hold_strobes", {obs_out_valid, obs_load, obs_ip, obs_key, obs_des, obs_fp}, 0);
        chk("rst_hold_busy_rev_ks_idx", {obs_busy, obs_rev, obs_ks, obs_ridx}, 0);
        chk("rst_hold_in_ready", obs_in_ready, 1);
        rst = 1'b0;
        run_block(1'b1, 1'b1, 8'd104, 3'b010, 6'b10_01_00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
